// File: rtl/lif_neuron_bank_pkg.sv
// Shared types for the LIF neuron bank: Q16.16 constants, state and reset-mode enums, saturating add.
// Pure declarations; no logic of its own.
// Imported by the bank and its update datapath.
package lif_bank_pkg;

    localparam logic signed [31:0] ONE        = 32'sh0001_0000;
    localparam logic signed [31:0] DEF_THRESH = 32'sh00C8_0000;

    typedef enum logic {
        RST_SUB,
        RST_ZERO
    } rst_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Operands arrive sign-extended to 64 bits; the result clamps to a w-bit signed range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/lif_neuron_bank_if.sv
// Event-in and spike-out handshakes of the neuron bank.
// slave = the bank; master = event source / spike consumer.
// Both channels are valid/ready.
interface lif_neuron_bank_if #(
    parameter int NEURONS = 16,
    parameter int DATA_W  = 32
);
    localparam int IDX_W = $clog2(NEURONS);

    logic                     in_valid;
    logic                     in_ready;
    logic [IDX_W-1:0]         in_idx;
    logic signed [DATA_W-1:0] in_weight;

    logic                     spike_valid;
    logic                     spike_ready;
    logic [IDX_W-1:0]         spike_idx;

    modport master (
        output in_valid, in_idx, in_weight, spike_ready,
        input  in_ready, spike_valid, spike_idx
    );

    modport slave (
        input  in_valid, in_idx, in_weight, spike_ready,
        output in_ready, spike_valid, spike_idx
    );
endinterface

// File: rtl/lif_neuron_update.sv
// Per-neuron leak / threshold / reset / refractory evaluation, shared across the sweep.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module lif_neuron_update #(
    parameter int DATA_W = 32,
    parameter int REFR_W = 4
) (
    input  logic signed [DATA_W-1:0] v_in,
    input  logic [REFR_W-1:0]        refr_in,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic [4:0]               decay_shift,
    input  lif_bank_pkg::rst_mode_e  reset_mode,
    input  logic [REFR_W-1:0]        refractory,
    output logic signed [DATA_W-1:0] v_next,
    output logic [REFR_W-1:0]        refr_next,
    output logic                     spike
);
    import lif_bank_pkg::*;

    logic signed [DATA_W-1:0] v_decay;

    always_comb begin
        v_decay = v_in;
        if (decay_shift != 5'd0) begin
            v_decay = v_in - (v_in >>> decay_shift);
        end

        v_next    = v_decay;
        refr_next = refr_in;
        spike     = 1'b0;
        // A refractory neuron is clamped silent; its leaked value is discarded.
        if (refr_in != '0) begin
            refr_next = refr_in - REFR_W'(1);
            v_next    = '0;
        end else if (v_decay >= threshold) begin
            spike     = 1'b1;
            refr_next = refractory;
            v_next    = (reset_mode == RST_ZERO) ? '0 : v_decay - threshold;
        end
    end
endmodule

// File: rtl/lif_neuron_bank.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons with saturating event accumulation.
// Latency: event visible next cycle; sweep of N neurons ends with step_done N+2 cycles after step_start.
// Backpressure: sweep stalls while a spike is held and spike_ready is low; in_ready is low outside IDLE.
module lif_neuron_bank #(
    parameter int                 NEURONS    = 16,
    parameter int                 DATA_W     = 32,
    parameter int                 REFR_W     = 4,
    parameter logic [DATA_W-1:0]  DEF_THRESH = 32'h00C8_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic signed [DATA_W-1:0]     cfg_threshold,
    input  logic [4:0]                   cfg_decay_shift,
    input  logic                         cfg_reset_mode,
    input  logic [REFR_W-1:0]            cfg_refractory,
    input  logic                         step_start,
    output logic                         step_done,
    input  logic [$clog2(NEURONS)-1:0]   rd_idx,
    output logic signed [DATA_W-1:0]     rd_potential,
    lif_neuron_bank_if.slave             bus
);
    import lif_bank_pkg::*;

    localparam int IDX_W = $clog2(NEURONS);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] v_q [NEURONS];
    logic signed [DATA_W-1:0] v_d [NEURONS];
    logic [REFR_W-1:0]        refr_q [NEURONS];
    logic [REFR_W-1:0]        refr_d [NEURONS];
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]         spike_idx_q, spike_idx_d;
    logic signed [DATA_W-1:0] thresh_q, thresh_d;
    logic [4:0]               shift_q, shift_d;
    rst_mode_e                mode_q, mode_d;
    logic [REFR_W-1:0]        refr_cfg_q, refr_cfg_d;

    logic [DEPTH-1:0]         idx_in_range;
    logic signed [DATA_W-1:0] upd_v;
    logic [REFR_W-1:0]        upd_refr;
    logic                     upd_spike;
    logic                     slot_free;

    // Index encodings beyond NEURONS-1 exist when NEURONS is not a power of two.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rng
        assign idx_in_range[k] = (k < NEURONS);
    end

    lif_neuron_update #(
        .DATA_W (DATA_W),
        .REFR_W (REFR_W)
    ) u_update (
        .v_in        (v_q[idx_q]),
        .refr_in     (refr_q[idx_q]),
        .threshold   (thresh_q),
        .decay_shift (shift_q),
        .reset_mode  (mode_q),
        .refractory  (refr_cfg_q),
        .v_next      (upd_v),
        .refr_next   (upd_refr),
        .spike       (upd_spike)
    );

    assign slot_free = !spike_valid_q || bus.spike_ready;

    always_comb begin
        state_d       = state_q;
        v_d           = v_q;
        refr_d        = refr_q;
        idx_d         = idx_q;
        spike_valid_d = spike_valid_q && !bus.spike_ready;
        spike_idx_d   = spike_idx_q;
        thresh_d      = thresh_q;
        shift_d       = shift_q;
        mode_d        = mode_q;
        refr_cfg_d    = refr_cfg_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    thresh_d   = cfg_threshold;
                    shift_d    = cfg_decay_shift;
                    mode_d     = cfg_reset_mode ? RST_ZERO : RST_SUB;
                    refr_cfg_d = cfg_refractory;
                end
                if (bus.in_valid && idx_in_range[bus.in_idx] && (refr_q[bus.in_idx] == '0)) begin
                    v_d[bus.in_idx] = DATA_W'(sat_add(
                        {{(64-DATA_W){v_q[bus.in_idx][DATA_W-1]}}, v_q[bus.in_idx]},
                        {{(64-DATA_W){bus.in_weight[DATA_W-1]}}, bus.in_weight},
                        DATA_W));
                end
                if (step_start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (slot_free) begin
                    v_d[idx_q]    = upd_v;
                    refr_d[idx_q] = upd_refr;
                    if (upd_spike) begin
                        spike_valid_d = 1'b1;
                        spike_idx_d   = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (slot_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            v_q           <= '{default: '0};
            refr_q        <= '{default: '0};
            idx_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            thresh_q      <= DEF_THRESH;
            shift_q       <= 5'd0;
            mode_q        <= RST_SUB;
            refr_cfg_q    <= '0;
        end else begin
            state_q       <= state_d;
            v_q           <= v_d;
            refr_q        <= refr_d;
            idx_q         <= idx_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            thresh_q      <= thresh_d;
            shift_q       <= shift_d;
            mode_q        <= mode_d;
            refr_cfg_q    <= refr_cfg_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE) && !reset;
    assign bus.spike_valid = spike_valid_q;
    assign bus.spike_idx   = spike_idx_q;
    assign step_done       = (state_q == ST_DONE);
    assign rd_potential    = v_q[rd_idx];
endmodule

// File: tb/tb_lif_neuron_bank.sv
// Directed stimulus with a spike scoreboard: expected indices are queued when a step is issued
// and a negedge monitor pops them on every spike handshake.
module tb_lif_neuron_bank;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [31:0] cfg_threshold;
    logic [4:0]  cfg_decay_shift;
    logic        cfg_reset_mode;
    logic [3:0]  cfg_refractory;
    logic        step_start;
    logic        step_done;
    logic [3:0]  rd_idx;
    logic [31:0] rd_potential;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_q[$];

    lif_neuron_bank_if #(.NEURONS(N), .DATA_W(32)) bus ();

    lif_neuron_bank #(
        .NEURONS(N), .DATA_W(32), .REFR_W(4), .DEF_THRESH(32'h00C8_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_we          (cfg_we),
        .cfg_threshold   (cfg_threshold),
        .cfg_decay_shift (cfg_decay_shift),
        .cfg_reset_mode  (cfg_reset_mode),
        .cfg_refractory  (cfg_refractory),
        .step_start      (step_start),
        .step_done       (step_done),
        .rd_idx          (rd_idx),
        .rd_potential    (rd_potential),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake completes at the next posedge.
    always @(negedge clk) begin
        if (step_done) done_cnt++;
        if (!reset && bus.spike_valid && bus.spike_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got spike %0d, expected none", bus.spike_idx);
            end else begin
                chk("sb_spike", 32'(bus.spike_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic ev(input int idx, input logic [31:0] w);
        bus.in_valid  = 1'b1;
        bus.in_idx    = 4'(idx);
        bus.in_weight = w;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] th, input int sh, input logic md, input int rf);
        cfg_we          = 1'b1;
        cfg_threshold   = th;
        cfg_decay_shift = 5'(sh);
        cfg_reset_mode  = md;
        cfg_refractory  = 4'(rf);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic chk_v(input string name, input int idx, input logic [31:0] exp);
        rd_idx = 4'(idx);
        #1;
        chk(name, rd_potential, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic do_step(input string name, input int exp_lat);
        int t;
        int k;
        @(posedge clk); #1;
        step_start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        step_start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!step_done && k < 300);
        chk({name, "_lat"}, 32'(cyc - t), 32'(exp_lat));
        chk({name, "_rdy_done"}, 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk({name, "_rdy_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        int d0;
        reset = 1'b1;
        cfg_we = 1'b0; cfg_threshold = '0; cfg_decay_shift = '0;
        cfg_reset_mode = 1'b0; cfg_refractory = '0;
        step_start = 1'b0; rd_idx = 4'd3;
        bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_weight = '0; bus.spike_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_spike_valid", 32'(bus.spike_valid), 32'd0);
        chk("rst_spike_idx", 32'(bus.spike_idx), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd0);
        chk("rst_v", rd_potential, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Subtract-threshold reset
        ev(3, 32'h0064_0000);
        chk_v("ev_visible_next", 3, 32'h0064_0000);
        ev(3, 32'h006E_0000);
        chk_v("ev_accum", 3, 32'h00D2_0000);
        exp_q.push_back(3);
        do_step("sub", N + 2);
        chk_v("sub_v3", 3, 32'h000A_0000);

        // Reset-to-zero
        do_reset();
        cfg(32'h00C8_0000, 0, 1'b1, 0);
        ev(3, 32'h0064_0000);
        ev(3, 32'h006E_0000);
        exp_q.push_back(3);
        do_step("zero", N + 2);
        chk_v("zero_v3", 3, 32'h0000_0000);

        // Decay by half, stays below threshold
        cfg(32'h00C8_0000, 1, 1'b0, 0);
        ev(5, 32'h0064_0000);
        do_step("decay", N + 2);
        chk_v("decay_v5", 5, 32'h0032_0000);

        // Saturation, both directions
        ev(0, 32'h7FFF_0000);
        chk_v("sat_pos_1", 0, 32'h7FFF_0000);
        ev(0, 32'h7FFF_0000);
        chk_v("sat_pos", 0, 32'h7FFF_FFFF);
        ev(2, 32'h8001_0000);
        ev(2, 32'h8001_0000);
        chk_v("sat_neg", 2, 32'h8000_0000);

        // Refractory: two silent steps, then a spike
        do_reset();
        cfg(32'h00C8_0000, 0, 1'b1, 2);
        ev(1, 32'h01F4_0000);
        exp_q.push_back(1);
        do_step("refr_s1", N + 2);
        chk_v("refr_v_s1", 1, 32'h0);
        ev(1, 32'h01F4_0000);
        chk_v("refr_discard_a", 1, 32'h0);
        do_step("refr_s2", N + 2);
        chk_v("refr_v_s2", 1, 32'h0);
        ev(1, 32'h01F4_0000);
        chk_v("refr_discard_b", 1, 32'h0);
        do_step("refr_s3", N + 2);
        chk_v("refr_v_s3", 1, 32'h0);
        ev(1, 32'h01F4_0000);
        chk_v("refr_accept", 1, 32'h01F4_0000);
        exp_q.push_back(1);
        do_step("refr_s4", N + 2);
        chk_v("refr_v_s4", 1, 32'h0);

        // Backpressure: five stalled cycles with a spike held
        do_reset();
        ev(0, 32'h00C8_0000);
        ev(1, 32'h00FA_0000);
        ev(15, 32'h012C_0000);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(15);
        bus.spike_ready = 1'b0;
        fork
            do_step("bp", N + 2 + 5);
            begin
                repeat (8) @(posedge clk);
                #1 bus.spike_ready = 1'b1;
            end
        join
        chk_v("bp_v0", 0, 32'h0);
        chk_v("bp_v1", 1, 32'h0032_0000);
        chk_v("bp_v15", 15, 32'h0064_0000);

        // Reset mid-sweep drops the pending spike and the step_done
        do_reset();
        ev(2, 32'h012C_0000);
        @(posedge clk); #1;
        step_start = 1'b1;
        bus.spike_ready = 1'b0;
        t = cyc;
        @(posedge clk); #1;
        step_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_cycle", 32'(cyc - t), 32'd4);
        chk("mid_pending", 32'(bus.spike_valid), 32'd1);
        chk("mid_pending_idx", 32'(bus.spike_idx), 32'd2);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_spike_valid", 32'(bus.spike_valid), 32'd0);
        chk("mid_spike_idx", 32'(bus.spike_idx), 32'd0);
        chk("mid_step_done", 32'(step_done), 32'd0);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
        chk_v("mid_v2", 2, 32'h0);
        bus.spike_ready = 1'b1;
        repeat (30) @(posedge clk);
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lif_neuron_bank.md
# lif_neuron_bank

Time-multiplexed bank of `NEURONS` leaky integrate-and-fire neurons in signed fixed point. It is the parametrised successor to the single-neuron potential adder.
- Between timesteps it accumulates weighted input events into per-neuron potentials with saturation.
- On each timestep pulse it sweeps every neuron once, applying decay, threshold, reset and refractory rules, and streams spike indices out through a valid/ready handshake.
- It sits between the NoC packet decoder (events in) and the spike packetiser (spikes out).

## Interface
Parameters:
- `NEURONS`, 16: neurons in the bank, ≥2.
- `DATA_W`, 32: potential and weight width, signed two's complement, Q(DATA_W-16).16.
- `REFR_W`, 4: refractory counter width.
- `DEF_THRESH`, 32'h00C8_0000: reset threshold (200.0).

Ports:
- `clk` input 1: clock. One clock domain; reset is synchronous and active-high.
- `reset` input 1: synchronous active-high reset.
- `cfg_we` input 1: configuration write. Honoured only in IDLE.
- `cfg_threshold` input DATA_W: threshold, positive.
- `cfg_decay_shift` input 5: leak shift. 0 disables decay.
- `cfg_reset_mode` input 1: 0 = subtract threshold, 1 = reset to zero.
- `cfg_refractory` input REFR_W: timesteps silent after a spike.
- `in_valid` input 1: weight event valid.
- `in_ready` output 1: event accepted when valid && ready.
- `in_idx` input $clog2(NEURONS): target neuron.
- `in_weight` input DATA_W: signed weight.
- `step_start` input 1: timestep pulse, honoured only in IDLE.
- `spike_valid` output 1: spike index valid.
- `spike_ready` input 1: consumer ready.
- `spike_idx` output $clog2(NEURONS): spiking neuron.
- `step_done` output 1: one-cycle pulse at sweep end.
- `rd_idx` input $clog2(NEURONS): debug read index.
- `rd_potential` output DATA_W: combinational potential of `rd_idx`.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- **Reset.** The following hold while `reset` is high and afterwards until changed:
  - all potentials 0 and refractory counters 0;
  - threshold = DEF_THRESH, shift 0, mode 0, refractory 0;
  - `spike_valid`, `spike_idx`, `step_done` = 0;
  - `in_ready` = 0; state = IDLE.
- **Reset mid-sweep.** Aborts the sweep with no `step_done`, and drops any pending spike.
- **IDLE.**
  - `in_ready` = 1.
  - An accepted event sets v[idx] = sat(v[idx] + weight), saturating to the signed max/min.
  - Events to neurons with a nonzero refractory count are accepted and discarded.
  - Events with idx ≥ NEURONS are accepted and discarded.
  - `step_start` moves to SWEEP with i = 0. An event offered in the same cycle is still accepted first.
- **SWEEP.**
  - `in_ready` = 0.
  - Neuron i is evaluated in a cycle only when the output slot is free, i.e. !spike_valid || spike_ready. Otherwise the sweep stalls.
  - If ref[i] > 0: ref[i]--, v[i] = 0, no spike.
  - Otherwise vd = v − (v >>> shift), skipped when shift = 0.
  - If vd ≥ threshold (signed compare): spike. Then v[i] = mode ? 0 : vd − threshold, and ref[i] = cfg_refractory. A spike registers `spike_valid` = 1 and `spike_idx` = i for the next cycle.
  - Else v[i] = vd.
  - After i = NEURONS−1, move to DRAIN.
- **Spike output.** `spike_valid` holds with a stable `spike_idx` until `spike_ready`. Spikes leave in ascending index order.
- **DRAIN.** Move to DONE once no spike is pending, i.e. !spike_valid, or spike_valid && spike_ready.
- **DONE.** `step_done` = 1 for one cycle, then IDLE.
- **Ignored inputs.** `step_start` and `cfg_we` outside IDLE are ignored.

## Timing
- **Event.** Accepted at cycle t; visible on `rd_potential` at t+1. Back-to-back events to the same neuron accumulate correctly at one per cycle.
- **Sweep without backpressure**, `step_start` sampled at t:
  - neuron i evaluated at t+1+i;
  - its spike visible at t+2+i;
  - DRAIN at t+N+1, `step_done` at t+N+2, `in_ready` = 1 at t+N+3.
- **Backpressure.** Each cycle of `spike_ready` low while `spike_valid` is high delays everything that follows by one cycle.

## Structure
- Package `lif_bank_pkg` holds:
  - the Q16.16 constants (ONE, DEF_THRESH);
  - a reset-mode enum (RST_SUB, RST_ZERO);
  - the state enum;
  - a `sat_add` function.
- Sub-module `lif_neuron_update` is combinational. It maps (v, ref, cfg) to (v_next, ref_next, spike) and is instantiated once, shared across the sweep.
- Potentials and refractory counters are register arrays with a combinational read.

## Test plan
- **Subtract reset.** Threshold 200.0, shift 0, mode 0; events 100.0 then 110.0 to neuron 3; step → single spike idx 3, v[3] = 0x000A_0000, `step_done` at t+18 with N = 16.
- **Zero reset and decay.** Same events, mode 1 → v[3] = 0 after spike. Separately, shift 1 with v[5] = 100.0 → no spike, v[5] = 50.0.
- **Saturation.** Two events of 0x7FFF_0000 to neuron 0 → v = 0x7FFF_FFFF; also a negative saturate to 0x8000_0000.
- **Refractory.** cfg_refractory 2: neuron 1 spikes, then receives 500.0 before each of the next two steps → no spikes, v = 0; spikes on the third step.
- **Backpressure.** Spikes on neurons 0, 1, 15 with `spike_ready` low for 5 cycles → indices 0, 1, 15 delivered in order, none lost or duplicated, `step_done` delayed by 5 cycles.
- **Reset mid-sweep.** `reset` at sweep cycle 4 → all outputs 0, potentials 0, no `step_done`; `in_ready` = 1 the cycle after reset deasserts.
